// File: rtl/wall_datapath.sv
// Wall datapath: owns the wall position, sweeps the wall rectangle to the VGA adapter and flags player contact.
// Optional feature macro WALL_WRAP_EN: a step below column 0 wraps to X_START instead of saturating at 0.
module wall_datapath #(
  parameter int          X_START     = 152,
  parameter int          WALL_Y      = 40,
  parameter int          WALL_W      = 8,
  parameter int          WALL_H      = 40,
  parameter int          STEP        = 1,
  parameter int          MOVE_DIV    = 833334,
  parameter int          SCREEN_W    = 160,
  parameter logic [2:0]  WALL_COLOUR = 3'b010,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       touched,
  output logic       busy,
  output logic [1:0] dbg_sweep_state
);

  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int PX_W  = (WALL_W > 1) ? $clog2(WALL_W) : 1;
  localparam int PY_W  = (WALL_H > 1) ? $clog2(WALL_H) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MOVE_DIV - 1);
  localparam logic [PX_W-1:0]  PX_LAST   = PX_W'(WALL_W - 1);
  localparam logic [PY_W-1:0]  PY_LAST   = PY_W'(WALL_H - 1);
  localparam logic [7:0]       X_START_8 = 8'(X_START);
  localparam logic [7:0]       STEP_8    = 8'(STEP);

  localparam logic [3:0] CMD_READY  = 4'd5;
  localparam logic [3:0] CMD_MOVE   = 4'd6;
  localparam logic [3:0] CMD_DRAW   = 4'd8;
  localparam logic [3:0] CMD_DEL    = 4'd9;
  localparam logic [3:0] CMD_UPDATE = 4'd10;

  typedef enum logic [1:0] {SW_IDLE = 2'd0, SW_ERASE = 2'd1, SW_DRAW = 2'd2} sweep_e;

  sweep_e           sweep_q, sweep_d, cur_type;
  logic [7:0]       wall_x_q, wall_x_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       erase_x_q, erase_x_d;
  logic             erase_pend_q, erase_pend_d;
  logic             draw_pend_q, draw_pend_d;
  logic [7:0]       base_q, base_d, cur_base;
  logic [PX_W-1:0]  px_q, px_d, cur_px;
  logic [PY_W-1:0]  py_q, py_d, cur_py;
  logic [7:0]       vga_x_q, vga_x_d;
  logic [6:0]       vga_y_q, vga_y_d;
  logic [2:0]       colour_q, colour_d;
  logic             plot_q, plot_d;
  logic             touched_q, touched_d;
  logic             busy_q, busy_d;

  logic             start, idle_now, step_moves;
  logic [7:0]       step_x;
  logic [8:0]       pix_x9;

  // Shared step rule for MOVE and UPDATE, including underflow handling.
  always_comb begin
`ifdef WALL_WRAP_EN
    step_x     = (wall_x_q < STEP_8) ? X_START_8 : wall_x_q - STEP_8;
    step_moves = 1'b1;
`else
    step_x     = (wall_x_q < STEP_8) ? 8'd0 : wall_x_q - STEP_8;
    step_moves = (wall_x_q != 8'd0);
`endif
  end

  always_comb begin
    wall_x_d     = wall_x_q;
    div_d        = div_q;
    erase_x_d    = erase_x_q;
    erase_pend_d = erase_pend_q;
    draw_pend_d  = draw_pend_q;
    sweep_d      = sweep_q;
    base_d       = base_q;
    px_d         = px_q;
    py_d         = py_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    pix_x9       = 9'd0;

    // A sweep leaving IDLE emits its first pixel on the same edge, which keeps back-to-back sweeps gapless.
    start    = (sweep_q == SW_IDLE) && (erase_pend_q || draw_pend_q);
    idle_now = (sweep_q == SW_IDLE) && !erase_pend_q && !draw_pend_q;
    cur_type = sweep_q;
    cur_base = base_q;
    cur_px   = px_q;
    cur_py   = py_q;
    if (start) begin
      cur_px = '0;
      cur_py = '0;
      if (erase_pend_q) begin
        cur_type     = SW_ERASE;
        cur_base     = erase_x_q;
        erase_pend_d = 1'b0;
      end else begin
        cur_type    = SW_DRAW;
        cur_base    = wall_x_q;
        draw_pend_d = 1'b0;
      end
    end

    if (cur_type != SW_IDLE) begin
      pix_x9   = {1'b0, cur_base} + 9'(cur_px);
      vga_x_d  = pix_x9[7:0];
      vga_y_d  = 7'(WALL_Y) + 7'(cur_py);
      colour_d = (cur_type == SW_ERASE) ? BG_COLOUR : WALL_COLOUR;
      plot_d   = (pix_x9 < 9'(SCREEN_W));
      base_d   = cur_base;
      if (cur_px == PX_LAST) begin
        px_d = '0;
        if (cur_py == PY_LAST) begin
          py_d    = '0;
          sweep_d = SW_IDLE;
        end else begin
          py_d    = cur_py + 1'b1;
          sweep_d = cur_type;
        end
      end else begin
        px_d    = cur_px + 1'b1;
        py_d    = cur_py;
        sweep_d = cur_type;
      end
    end

    // Requests are applied after the start-of-sweep clear so a same-edge request is not lost.
    case (state)
      CMD_READY: begin
        wall_x_d = X_START_8;
        div_d    = '0;
      end
      CMD_MOVE: begin
        if (div_q == DIV_LAST) begin
          if (idle_now) begin
            div_d = '0;
            if (step_moves) begin
              wall_x_d     = step_x;
              erase_x_d    = wall_x_q;
              erase_pend_d = 1'b1;
              draw_pend_d  = 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      CMD_DRAW:   draw_pend_d = 1'b1;
      CMD_DEL: begin
        erase_pend_d = 1'b1;
        erase_x_d    = wall_x_q;
      end
      CMD_UPDATE: wall_x_d = step_x;
      default: ;
    endcase

    busy_d    = (sweep_d != SW_IDLE) || erase_pend_d || draw_pend_d;
    touched_d = ({1'b0, player_x} >= {1'b0, wall_x_q}) &&
                ({1'b0, player_x} <= {1'b0, wall_x_q} + 9'(WALL_W - 1)) &&
                ({2'b0, player_y} >= 9'(WALL_Y)) &&
                ({2'b0, player_y} <= 9'(WALL_Y + WALL_H - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_q      <= SW_IDLE;
      wall_x_q     <= X_START_8;
      div_q        <= '0;
      erase_x_q    <= '0;
      erase_pend_q <= 1'b0;
      draw_pend_q  <= 1'b0;
      base_q       <= '0;
      px_q         <= '0;
      py_q         <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      touched_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sweep_q      <= sweep_d;
      wall_x_q     <= wall_x_d;
      div_q        <= div_d;
      erase_x_q    <= erase_x_d;
      erase_pend_q <= erase_pend_d;
      draw_pend_q  <= draw_pend_d;
      base_q       <= base_d;
      px_q         <= px_d;
      py_q         <= py_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      touched_q    <= touched_d;
      busy_q       <= busy_d;
    end
  end

  assign vga_x           = vga_x_q;
  assign vga_y           = vga_y_q;
  assign vga_colour      = colour_q;
  assign plot            = plot_q;
  assign touched         = touched_q;
  assign busy            = busy_q;
  assign dbg_sweep_state = sweep_q;

endmodule

// File: tb/tb_wall_datapath.sv
// Bench for wall_datapath: directed scenarios plus randomized moves/requests against a pixel-list reference model.
// Handshake: state is a level command sampled every posedge; pixels are taken whenever plot is high.
module tb_wall_datapath;

  localparam logic [3:0] C_READY = 4'd5, C_MOVE = 4'd6, C_STOP = 4'd7;
  localparam logic [3:0] C_DRAW = 4'd8, C_DEL = 4'd9, C_UPDATE = 4'd10;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, touched, busy;
  logic [1:0] dbg_sweep_state;

  int tests_run = 0;
  int tests_failed = 0;
  int model_x;
  int waits;
  logic [18:0] exp_q[$];

  wall_datapath #(.MOVE_DIV(4)) dut (
    .clk(clk), .reset(reset), .state(state), .player_x(player_x), .player_y(player_y),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot),
    .touched(touched), .busy(busy), .dbg_sweep_state(dbg_sweep_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: a sweep is the row-major list of wall pixels at a given base column.
  task automatic push_sweep(input int base, input logic [2:0] col);
    for (int py = 0; py < 40; py++) begin
      for (int px = 0; px < 8; px++) begin
        int x;
        x = base + px;
        exp_q.push_back({(x < 160) ? 1'b1 : 1'b0, 8'(x), 7'(40 + py), col});
      end
    end
  endtask

  task automatic drain(input string tag, input int pulse_a, input int pulse_b,
                       input int abort_at, output int nwait);
    int i;
    nwait = 0;
    @(negedge clk);
    while (plot !== 1'b1 && nwait < 50) begin
      nwait++;
      @(negedge clk);
    end
    if (plot !== 1'b1) begin
      check({tag, "_start_timeout"}, 32'd0, 32'd1);
      exp_q.delete();
      return;
    end
    i = 0;
    while (exp_q.size() > 0) begin
      logic [18:0] e;
      e = exp_q.pop_front();
      check({tag, "_pix"}, {13'd0, plot, vga_x, vga_y, vga_colour}, {13'd0, e});
      if (i == abort_at) return;
      state = (i == pulse_a || i == pulse_b) ? C_DRAW : C_STOP;
      i++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    state = C_STOP;
  endtask

  task automatic touch_check(input string tag, input int px, input int py);
    logic expv;
    player_x = 8'(px);
    player_y = 7'(py);
    @(negedge clk);
    expv = (px >= model_x) && (px <= model_x + 7) && (py >= 40) && (py <= 79);
    check(tag, {31'd0, touched}, {31'd0, expv});
  endtask

  task automatic quiet_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check({tag, "_plot"}, {31'd0, plot}, 32'd0);
    end
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_vga_x"}, {24'd0, vga_x}, 32'd0);
    check({tag, "_vga_y"}, {25'd0, vga_y}, 32'd0);
    check({tag, "_colour"}, {29'd0, vga_colour}, 32'd0);
    check({tag, "_plot"}, {31'd0, plot}, 32'd0);
    check({tag, "_touched"}, {31'd0, touched}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    state = 4'd0;
    player_x = 8'd0;
    player_y = 7'd0;
    model_x = 152;
    @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;

    // 1: READY then one-cycle DRAW
    state = C_READY;
    @(negedge clk);
    state = C_DRAW;
    @(negedge clk);
    state = C_STOP;
    check("t1_busy_pending", {31'd0, busy}, 32'd1);
    check("t1_plot_before_first", {31'd0, plot}, 32'd0);
    push_sweep(152, 3'b010);
    drain("t1", -1, -1, -1, waits);
    check("t1_latency", waits, 32'd0);
    quiet_check("t1_after", 1);

    // 2: READY then MOVE_DIV move cycles -> erase old column, draw new column
    state = C_READY;
    @(negedge clk);
    state = C_MOVE;
    repeat (4) @(negedge clk);
    state = C_STOP;
    push_sweep(152, 3'b000);
    push_sweep(151, 3'b010);
    model_x = 151;
    drain("t2", -1, -1, -1, waits);
    check("t2_latency", waits, 32'd0);
    quiet_check("t2_after", 1);

    // 3: two DRAW pulses during an active draw merge into one extra sweep
    state = C_DRAW;
    @(negedge clk);
    state = C_STOP;
    push_sweep(151, 3'b010);
    push_sweep(151, 3'b010);
    drain("t3", 50 + $urandom_range(0, 20), 120 + $urandom_range(0, 100), -1, waits);
    quiet_check("t3_after", 3);

    // 4: touched boundaries at wall_x = 151
    touch_check("t4_inside", 151, 50);
    touch_check("t4_left_out", 150, 50);
    touch_check("t4_below_out", 151, 80);
    touch_check("t4_right_edge", 158, 79);
    touch_check("t4_right_out", 159, 79);
    touch_check("t4_top_edge", 151, 40);
    touch_check("t4_above_out", 151, 39);
    state = C_UPDATE;
    @(negedge clk);
    state = C_STOP;
    model_x = 150;
    touch_check("t4_after_update", 150, 50);

    // randomized: UPDATE steps followed by a DRAW or DEL request
    for (int r = 0; r < 6; r++) begin
      int n, kind;
      n = $urandom_range(1, 5);
      state = C_UPDATE;
      repeat (n) @(negedge clk);
      model_x -= n;
      state = C_STOP;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      kind = $urandom_range(0, 1);
      state = (kind == 1) ? C_DRAW : C_DEL;
      @(negedge clk);
      state = C_STOP;
      push_sweep(model_x, (kind == 1) ? 3'b010 : 3'b000);
      drain("rnd", -1, -1, -1, waits);
      for (int t = 0; t < 3; t++)
        touch_check("rnd_touch", model_x - 2 + $urandom_range(0, 11), $urandom_range(37, 82));
    end

    // 5: reset in the middle of a sweep
    state = C_DRAW;
    @(negedge clk);
    state = C_STOP;
    push_sweep(model_x, 3'b010);
    drain("t5", -1, -1, 100, waits);
    exp_q.delete();
    reset = 1'b1;
    #1;
    check_zero_outputs("t5_async_reset");
    @(negedge clk);
    check("t5_plot_in_reset", {31'd0, plot}, 32'd0);
    reset = 1'b0;
    model_x = 152;
    touch_check("t5_x_restored", 152, 40);
    touch_check("t5_x_restored_left", 151, 40);
    state = C_DRAW;
    @(negedge clk);
    state = C_STOP;
    push_sweep(152, 3'b010);
    drain("t5_redraw", -1, -1, -1, waits);

    // 6: drive the wall to column 0 and step once more
    state = C_UPDATE;
    repeat (152) @(negedge clk);
    state = C_STOP;
    model_x = 0;
    touch_check("t6_at_zero", 0, 40);
    touch_check("t6_at_zero_right_out", 8, 40);
    state = C_MOVE;
    repeat (4) @(negedge clk);
    state = C_STOP;
`ifdef WALL_WRAP_EN
    push_sweep(0, 3'b000);
    push_sweep(152, 3'b010);
    model_x = 152;
    drain("t6_wrap", -1, -1, -1, waits);
    check("t6_wrap_latency", waits, 32'd0);
    quiet_check("t6_wrap_after", 2);
    touch_check("t6_wrap_new_x", 152, 40);
    touch_check("t6_wrap_old_x", 0, 40);
`else
    quiet_check("t6_sat", 30);
    touch_check("t6_sat_x", 0, 40);
    state = C_UPDATE;
    @(negedge clk);
    state = C_STOP;
    touch_check("t6_sat_update", 0, 79);
    quiet_check("t6_sat_update", 5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
